// File: rtl/vx_mem_lane_seq.sv
//==============================================================================
// Module      : vx_mem_lane_seq
// Description : Serializes a multi-lane load/store from the E/M register onto
//               a single-lane data-memory port and gathers load data per lane.
//               Optional load coalescing is enabled by VX_MEM_COALESCE_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vx_mem_lane_seq #(
    parameter int NT       = 4,
    parameter int NT_IDX_W = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NT-1:0]       in_valid,
    input  logic [2:0]          in_mem_read,
    input  logic [2:0]          in_mem_write,
    input  logic [NT*32-1:0]    in_addr,
    input  logic [NT*32-1:0]    in_wdata,
    output logic                out_freeze,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [31:0]         mem_req_addr,
    output logic [31:0]         mem_req_wdata,
    output logic                mem_req_we,
    output logic [2:0]          mem_req_type,
    output logic [NT_IDX_W-1:0] mem_req_lane,
    input  logic                mem_rsp_valid,
    input  logic [31:0]         mem_rsp_data,
    output logic [NT*32-1:0]    out_rdata,
    output logic                out_done,
    output logic [NT-1:0]       out_valid
);

    localparam logic [2:0] C_NO_MEM = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [NT-1:0]       r_pending;
    logic [NT-1:0]       r_mask;
    logic [NT*32-1:0]    r_addr;
    logic [NT*32-1:0]    r_wdata;
    logic [NT*32-1:0]    r_rdata;
    logic [2:0]          r_type;
    logic                r_we;
    logic                r_coalesce;

    logic                w_is_read;
    logic                w_is_write;
    logic                w_mem_op;
    logic                w_coal;
    logic [NT_IDX_W-1:0] w_lane;
    logic [NT-1:0]       w_lane_bit;
    logic [NT-1:0]       w_pending_clr;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;

    assign w_is_read  = (in_mem_read != C_NO_MEM);
    assign w_is_write = (in_mem_write != C_NO_MEM);
    assign w_mem_op   = (w_is_read || w_is_write) && (in_valid != '0);

    // Lowest pending lane is serviced first
    always_comb begin
        w_lane     = '0;
        w_lane_bit = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_lane        = NT_IDX_W'(i);
                w_lane_bit    = '0;
                w_lane_bit[i] = 1'b1;
            end
        end
    end

    assign w_pending_clr = r_pending & ~w_lane_bit;

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NT; i++) begin
            if (w_lane_bit[i]) begin
                w_sel_addr  = r_addr[32*i +: 32];
                w_sel_wdata = r_wdata[32*i +: 32];
            end
        end
    end

`ifdef VX_MEM_COALESCE_EN
    logic [29:0] w_ref_word;

    // A load coalesces when every active lane hits the same 32-bit word
    always_comb begin
        w_ref_word = '0;
        for (int i = NT - 1; i >= 0; i--) begin
            if (in_valid[i]) w_ref_word = in_addr[32*i+2 +: 30];
        end
        w_coal = w_is_read;
        for (int i = 0; i < NT; i++) begin
            if (in_valid[i] && (in_addr[32*i+2 +: 30] != w_ref_word)) w_coal = 1'b0;
        end
    end
`else
    assign w_coal = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_mem_op) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_req_ready) begin
                    if (!r_we)                     w_state_nxt = S_WAIT_RSP;
                    else if (w_pending_clr == '0)  w_state_nxt = S_DONE;
                end
            end
            S_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    if (r_coalesce || (w_pending_clr == '0)) w_state_nxt = S_DONE;
                    else                                     w_state_nxt = S_ISSUE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_mask     <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_type     <= '0;
            r_we       <= 1'b0;
            r_coalesce <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_pending  <= in_valid;
                        r_mask     <= in_valid;
                        r_addr     <= in_addr;
                        r_wdata    <= in_wdata;
                        r_type     <= w_is_read ? in_mem_read : in_mem_write;
                        r_we       <= !w_is_read;
                        r_coalesce <= w_coal;
                    end
                end
                S_ISSUE: begin
                    if (mem_req_ready && r_we) r_pending <= w_pending_clr;
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        for (int i = 0; i < NT; i++) begin
                            if (r_coalesce ? r_pending[i] : w_lane_bit[i])
                                r_rdata[32*i +: 32] <= mem_rsp_data;
                        end
                        r_pending <= r_coalesce ? '0 : w_pending_clr;
                    end
                end
                default: ;
            endcase
        end
    end

    // Freeze is raised in the detect cycle itself so the E/M register holds
    assign out_freeze    = (reset_n && (r_state == S_IDLE) && w_mem_op)
                         || (r_state == S_ISSUE) || (r_state == S_WAIT_RSP);
    assign mem_req_valid = (r_state == S_ISSUE);
    assign mem_req_addr  = mem_req_valid ? w_sel_addr  : '0;
    assign mem_req_wdata = mem_req_valid ? w_sel_wdata : '0;
    assign mem_req_we    = mem_req_valid && r_we;
    assign mem_req_type  = mem_req_valid ? r_type : '0;
    assign mem_req_lane  = mem_req_valid ? w_lane : '0;
    assign out_done      = (r_state == S_DONE);
    assign out_valid     = r_mask;
    assign out_rdata     = r_rdata;

endmodule

`default_nettype wire
